// File: rtl/rx_pkg.sv
// Shared definitions for the RX frame controller: FSM encoding and frame defaults.
package rx_pkg;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hA5C3;
  localparam int unsigned HUNT_MAX_DEF  = 1024;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned SYNC_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HUNT    = 2'd1,
    ST_LEN     = 2'd2,
    ST_PAYLOAD = 2'd3
  } rx_state_e;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: counts 0..period while running and strobes dump on the last count.
module bit_timer
  import rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] period,
  input  logic              run,
  output logic              dump
);

  logic [BYTE_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!run || (r_cnt == period)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + BYTE_W'(1);
    end
  end

  // Decoded from registered count and run, so dump is low whenever idle.
  assign dump = run && (r_cnt == period);

endmodule

// File: rtl/rx_frame_ctrl.sv
// Frame receive controller: hunts for sync, reads a length byte, then delivers
// N payload bytes over a valid/ready handshake while pacing the demodulator.
module rx_frame_ctrl
  import rx_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int unsigned HUNT_MAX  = HUNT_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_cfg,
  input  logic [BYTE_W-1:0] bit_len,
  output logic              dump,
  output logic              mode_sel,
  input  logic              dec_bit,
  input  logic              dec_valid,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout,
  output logic              overflow
);

  localparam int unsigned CNT_W = ($clog2(HUNT_MAX + 1) < 3) ? 3 : $clog2(HUNT_MAX + 1);

  rx_state_e         r_state;
  rx_state_e         w_state_nxt;

  logic [BYTE_W-1:0] r_period;
  logic              r_mode;
  logic [SYNC_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [BYTE_W-1:0] r_acc;
  logic [BYTE_W-1:0] r_bytes_left;
  logic [BYTE_W-1:0] r_byte_data;
  logic              r_byte_valid;
  logic              r_frame_done;
  logic              r_timeout;
  logic              r_overflow;
  logic              r_busy;

  logic              w_start;
  logic              w_consume;
  logic [SYNC_W-1:0] w_shift_nxt;
  logic [BYTE_W-1:0] w_acc_nxt;
  logic              w_oct_done;
  logic              w_sync_hit;
  logic              w_hunt_exp;
  logic              w_len_zero;
  logic              w_byte_done;
  logic              w_last_byte;

  bit_timer u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .period (r_period),
    .run    (r_busy),
    .dump   (dump)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Per-cycle frame events derived from the current state and incoming bit.
  always_comb begin
    w_start     = 1'b0;
    w_consume   = 1'b0;
    w_shift_nxt = {r_shift[SYNC_W-2:0], dec_bit};
    w_acc_nxt   = {r_acc[BYTE_W-2:0], dec_bit};
    w_oct_done  = 1'b0;
    w_sync_hit  = 1'b0;
    w_hunt_exp  = 1'b0;
    w_len_zero  = 1'b0;
    w_byte_done = 1'b0;
    w_last_byte = 1'b0;

    w_start    = (r_state == ST_IDLE) && start;
    w_consume  = (r_state != ST_IDLE) && dec_valid;
    w_oct_done = w_consume && ((r_state == ST_LEN) || (r_state == ST_PAYLOAD)) &&
                 (r_bit_cnt == CNT_W'(7));
    w_sync_hit = w_consume && (r_state == ST_HUNT) && (w_shift_nxt == SYNC_WORD);
    w_hunt_exp = w_consume && (r_state == ST_HUNT) && !w_sync_hit &&
                 (r_bit_cnt == CNT_W'(HUNT_MAX - 1));
    w_len_zero  = w_oct_done && (r_state == ST_LEN) && (w_acc_nxt == '0);
    w_byte_done = w_oct_done && (r_state == ST_PAYLOAD);
    w_last_byte = w_byte_done && (r_bytes_left == BYTE_W'(1));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_HUNT;
      end
      ST_HUNT: begin
        if (w_sync_hit)      w_state_nxt = ST_LEN;
        else if (w_hunt_exp) w_state_nxt = ST_IDLE;
      end
      ST_LEN: begin
        if (w_oct_done) w_state_nxt = w_len_zero ? ST_IDLE : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (w_last_byte) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period     <= '0;
      r_mode       <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_acc        <= '0;
      r_bytes_left <= '0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_timeout    <= 1'b0;
      r_overflow   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= w_len_zero || w_last_byte;
      r_timeout    <= w_hunt_exp;
      r_busy       <= (w_state_nxt != ST_IDLE);

      if (w_start) begin
        r_mode     <= mode_cfg;
        r_period   <= bit_len;
        r_overflow <= 1'b0;
        r_shift    <= '0;
        r_bit_cnt  <= '0;
        r_acc      <= '0;
      end else if (w_consume) begin
        r_shift <= w_shift_nxt;
        r_acc   <= w_acc_nxt;
        if (w_sync_hit || w_hunt_exp || w_oct_done) begin
          r_bit_cnt <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
        if (w_oct_done && (r_state == ST_LEN)) begin
          r_bytes_left <= w_acc_nxt;
        end else if (w_byte_done) begin
          r_bytes_left <= r_bytes_left - BYTE_W'(1);
        end
      end

      // A completed byte always wins the output slot; it is only lost if unaccepted.
      if (w_byte_done) begin
        r_byte_data  <= w_acc_nxt;
        r_byte_valid <= 1'b1;
        if (r_byte_valid && !byte_ready) r_overflow <= 1'b1;
      end else if (r_byte_valid && byte_ready) begin
        r_byte_valid <= 1'b0;
      end
    end
  end

  assign mode_sel   = r_mode;
  assign byte_data  = r_byte_data;
  assign byte_valid = r_byte_valid;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign timeout    = r_timeout;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: frame-parsing reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rx_frame_ctrl;

  localparam logic [15:0] SYNC = 16'hA5C3;
  localparam int          HMAX = 1024;

  logic       clk = 1'b0;
  logic       rst, start, mode_cfg, dec_bit, dec_valid, byte_ready;
  logic [7:0] bit_len;
  logic       dump, mode_sel, byte_valid, busy, frame_done, timeout, overflow;
  logic [7:0] byte_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic tb_abort = 1'b0;

  always #5 clk = ~clk;

  rx_frame_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode_cfg   (mode_cfg),
    .bit_len    (bit_len),
    .dump       (dump),
    .mode_sel   (mode_sel),
    .dec_bit    (dec_bit),
    .dec_valid  (dec_valid),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .timeout    (timeout),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: parses the consumed bit history of the current frame.
  logic       m_busy, m_mode, m_bv, m_fd, m_to, m_ov, m_deliver, m_xfer;
  logic [7:0] m_period, m_bd, m_newb, m_v8;
  logic [15:0] m_w16;
  int         m_since, m_nb, m_sync_at, m_len, m_rel;
  logic       m_bits [0:4095];
  logic       exp_dump;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_mode = 0; m_bv = 0; m_fd = 0; m_to = 0; m_ov = 0;
        m_period = 0; m_bd = 0; m_since = 0; m_nb = 0; m_sync_at = -1; m_len = 0;
      end else begin
        m_xfer = m_bv && byte_ready;
        m_deliver = 0; m_newb = 0; m_fd = 0; m_to = 0;
        if (!m_busy) begin
          if (start) begin
            m_busy = 1; m_mode = mode_cfg; m_period = bit_len; m_ov = 0;
            m_since = 1; m_nb = 0; m_sync_at = -1; m_len = 0;
          end
        end else begin
          m_since++;
          if (dec_valid) begin
            m_bits[m_nb] = dec_bit;
            m_nb++;
            if (m_sync_at < 0) begin
              m_w16 = '0;
              for (int i = (m_nb > 16 ? m_nb - 16 : 0); i < m_nb; i++) m_w16 = {m_w16[14:0], m_bits[i]};
              if (m_w16 == SYNC) m_sync_at = m_nb;
              else if (m_nb == HMAX) begin m_to = 1; m_busy = 0; end
            end else begin
              m_rel = m_nb - m_sync_at;
              if (m_rel % 8 == 0) begin
                m_v8 = '0;
                for (int i = m_nb - 8; i < m_nb; i++) m_v8 = {m_v8[6:0], m_bits[i]};
                if (m_rel == 8) begin
                  m_len = int'(m_v8);
                  if (m_len == 0) begin m_fd = 1; m_busy = 0; end
                end else begin
                  m_deliver = 1; m_newb = m_v8;
                  if ((m_rel - 8) / 8 == m_len) begin m_fd = 1; m_busy = 0; end
                end
              end
            end
          end
        end
        if (m_deliver) begin
          if (m_bv && !byte_ready) m_ov = 1;
          m_bv = 1; m_bd = m_newb;
        end else if (m_xfer) begin
          m_bv = 0;
        end
      end
      #1;
      exp_dump = m_busy && ((m_since % (int'(m_period) + 1)) == 0);
      check("busy",       32'(busy),       32'(m_busy));
      check("mode_sel",   32'(mode_sel),   32'(m_mode));
      check("dump",       32'(dump),       32'(exp_dump));
      check("byte_valid", 32'(byte_valid), 32'(m_bv));
      check("byte_data",  32'(byte_data),  32'(m_bd));
      check("overflow",   32'(overflow),   32'(m_ov));
      check("frame_done", 32'(frame_done), 32'(m_fd));
      check("timeout",    32'(timeout),    32'(m_to));
    end
  end

  // Event monitors sampled at the active edge (transfer semantics).
  logic [7:0] got_q [$];
  int fd_cnt = 0, to_cnt = 0, bv_cnt = 0;
  always @(posedge clk) begin
    if (byte_valid && byte_ready) got_q.push_back(byte_data);
    if (frame_done) fd_cnt++;
    if (timeout) to_cnt++;
    if (byte_valid) bv_cnt++;
  end

  task automatic do_start(input logic m, input logic [7:0] bl);
    start = 1; mode_cfg = m; bit_len = bl;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send_bit(input logic b);
    int w;
    w = 0;
    if (tb_abort) return;
    while (!dump && w < 600) begin @(negedge clk); w++; end
    if (!dump) begin
      check("dump_wait", 32'(0), 32'(1));
      tb_abort = 1;
      return;
    end
    @(negedge clk);
    dec_valid = 1; dec_bit = b;
    @(negedge clk);
    dec_valid = 0;
  endtask

  task automatic send_val(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcyc [$];
    int fd0, to0, bv0, q0;
    rst = 1; start = 0; mode_cfg = 0; bit_len = 8'd3;
    dec_bit = 0; dec_valid = 0; byte_ready = 1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_bv",   32'(byte_valid), 32'(0));
    check("rst_dump", 32'(dump), 32'(0));
    rst = 0;
    @(negedge clk);

    // Dump timing, with an ignored start while busy.
    start = 1; mode_cfg = 1; bit_len = 8'd7;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      start = 0;
      if (c == 3) begin start = 1; mode_cfg = 0; bit_len = 8'd2; end
      if (dump) dcyc.push_back(c);
    end
    start = 0;
    check("dump_count", 32'(dcyc.size()), 32'(3));
    check("dump_1st", 32'(dcyc.size() > 0 ? dcyc[0] : -1), 32'(8));
    check("dump_2nd", 32'(dcyc.size() > 1 ? dcyc[1] : -1), 32'(16));
    check("dump_3rd", 32'(dcyc.size() > 2 ? dcyc[2] : -1), 32'(24));
    check("mode_latched", 32'(mode_sel), 32'(1));
    rst = 1; @(negedge clk); rst = 0;

    // Normal frame: length 2, bytes 0x3C 0x81.
    byte_ready = 1;
    fd0 = fd_cnt; q0 = got_q.size();
    do_start(0, 8'd3);
    send_val(SYNC, 16);
    send_val(16'h0002, 8);
    send_val(16'h003C, 8);
    send_val(16'h0081, 8);
    repeat (3) @(negedge clk);
    check("norm_nbytes", 32'(got_q.size() - q0), 32'(2));
    check("norm_byte0", 32'(got_q.size() > q0 ? got_q[q0] : 8'hxx), 32'(8'h3C));
    check("norm_byte1", 32'(got_q.size() > q0 + 1 ? got_q[q0+1] : 8'hxx), 32'(8'h81));
    check("norm_fd", 32'(fd_cnt - fd0), 32'(1));
    check("norm_ovf", 32'(overflow), 32'(0));
    check("norm_idle", 32'(busy), 32'(0));

    // dec_valid in IDLE must not start anything.
    dec_valid = 1; dec_bit = 1;
    repeat (3) @(negedge clk);
    dec_valid = 0;
    check("idle_ignore", 32'(busy), 32'(0));

    // Zero-length frame.
    fd0 = fd_cnt; bv0 = bv_cnt;
    do_start(1, 8'd4);
    send_val(SYNC, 16);
    send_val(16'h0000, 8);
    repeat (3) @(negedge clk);
    check("zero_fd", 32'(fd_cnt - fd0), 32'(1));
    check("zero_nobv", 32'(bv_cnt - bv0), 32'(0));
    check("zero_idle", 32'(busy), 32'(0));

    // Timeout after HMAX zero bits, none before.
    fd0 = fd_cnt; to0 = to_cnt;
    do_start(0, 8'd3);
    for (int i = 0; i < HMAX - 1; i++) send_bit(1'b0);
    repeat (2) @(negedge clk);
    check("to_not_early", 32'(to_cnt - to0), 32'(0));
    check("to_busy_before", 32'(busy), 32'(1));
    send_bit(1'b0);
    repeat (3) @(negedge clk);
    check("to_pulse", 32'(to_cnt - to0), 32'(1));
    check("to_fd", 32'(fd_cnt - fd0), 32'(0));
    check("to_idle", 32'(busy), 32'(0));

    // Overflow with no downstream acceptance; pending byte survives IDLE.
    byte_ready = 0;
    do_start(1, 8'd3);
    send_val(SYNC, 16);
    send_val(16'h0002, 8);
    send_val(16'h005A, 8);
    send_val(16'h00C7, 8);
    repeat (3) @(negedge clk);
    check("ovf_set", 32'(overflow), 32'(1));
    check("ovf_data", 32'(byte_data), 32'(8'hC7));
    check("ovf_pending", 32'(byte_valid), 32'(1));
    check("ovf_idle", 32'(busy), 32'(0));
    do_start(0, 8'd3);
    check("ovf_cleared", 32'(overflow), 32'(0));
    check("ovf_still_pending", 32'(byte_valid), 32'(1));
    q0 = got_q.size();
    byte_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("ovf_drain", 32'(got_q.size() > q0 ? got_q[q0] : 8'hxx), 32'(8'hC7));
    check("ovf_bv_clear", 32'(byte_valid), 32'(0));
    rst = 1; @(negedge clk); rst = 0;

    // Reset in the middle of the payload drops the pending byte.
    byte_ready = 0;
    fd0 = fd_cnt;
    do_start(1, 8'd3);
    send_val(SYNC, 16);
    send_val(16'h0002, 8);
    send_val(16'h0011, 8);
    send_val(16'h0005, 3);
    check("mid_pending", 32'(byte_valid), 32'(1));
    check("mid_busy", 32'(busy), 32'(1));
    rst = 1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_bv", 32'(byte_valid), 32'(0));
    check("mid_rst_bd", 32'(byte_data), 32'(0));
    check("mid_rst_mode", 32'(mode_sel), 32'(0));
    check("mid_rst_dump", 32'(dump), 32'(0));
    rst = 0;
    byte_ready = 1;
    repeat (4) @(negedge clk);
    check("mid_no_fd", 32'(fd_cnt - fd0), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 16'hA5C3: frame sync pattern, compared MSB-first.
REQ-002 SHALL have parameter HUNT_MAX, default 1024: maximum number of bits searched for sync before timeout.
REQ-003 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse that arms frame reception.
REQ-006 SHALL have port mode_cfg, input, 1: requested demod mode (0 BPSK, 1 ASK).
REQ-007 SHALL have port bit_len, input, 8: bit period minus 1, in clk cycles; legal range 3..255.
REQ-008 SHALL have port dump, output, 1: integrate-and-dump strobe to the demodulator.
REQ-009 SHALL have port mode_sel, output, 1: mode driven to the demodulator.
REQ-010 SHALL have port dec_bit, input, 1: demodulated bit decision.
REQ-011 SHALL have port dec_valid, input, 1: dec_bit is valid this cycle.
REQ-012 SHALL have port byte_data, output, 8: payload byte.
REQ-013 SHALL have port byte_valid, output, 1: byte_data is valid.
REQ-014 SHALL have port byte_ready, input, 1: downstream accepts the byte.
REQ-015 SHALL have port busy, output, 1: FSM is not in IDLE.
REQ-016 SHALL have port frame_done, output, 1: one-cycle pulse at end of frame.
REQ-017 SHALL have port timeout, output, 1: one-cycle pulse when sync is not found.
REQ-018 SHALL have port overflow, output, 1: sticky; a payload byte was lost.

Function
REQ-019 SHALL implement FSM states IDLE, HUNT, LEN, PAYLOAD.
REQ-020 IDLE: on start, SHALL latch mode_cfg into mode_sel and bit_len into a period register, clear overflow and the shift/bit counters, and go to HUNT.
REQ-021 A start pulse while busy=1 SHALL be ignored.
REQ-022 When busy=1, a cycle counter SHALL run 0..period; dump SHALL be 1 exactly when count==period, after which the counter wraps to 0; dump=1 every period+1 cycles.
REQ-023 When busy=0, dump SHALL be 0 and the counter held at 0; the first dump SHALL occur period+1 cycles after the start cycle.
REQ-024 Bits SHALL be consumed only on dec_valid=1 (any latency after dump); dec_valid SHALL be ignored in IDLE.
REQ-025 HUNT: each consumed bit SHALL be shifted into a 16-bit register, LSB-in. When the post-shift value equals SYNC_WORD, the FSM SHALL go to LEN. After HUNT_MAX bits without a match, it SHALL pulse timeout and go to IDLE.
REQ-026 LEN: SHALL collect 8 bits MSB-first as length N. If N==0, it SHALL pulse frame_done and go to IDLE; otherwise it SHALL go to PAYLOAD.
REQ-027 PAYLOAD: SHALL assemble bytes MSB-first. On the 8th bit, the byte SHALL be loaded into byte_data with byte_valid=1 in the next cycle. After N bytes, it SHALL pulse frame_done (same cycle the last byte_valid rises) and go to IDLE.
REQ-028 Handshake: byte_valid SHALL stay 1 and byte_data stay stable until byte_valid&&byte_ready; byte_valid SHALL clear the cycle after the transfer.
REQ-029 If a byte completes while byte_valid=1 and byte_ready=0, the new byte SHALL overwrite byte_data and overflow SHALL set.
REQ-030 If a byte completes in the same cycle as a transfer, there SHALL be no overflow; the new byte loads and byte_valid stays 1.
REQ-031 A pending byte SHALL remain offered after the FSM returns to IDLE.
REQ-032 mode_sel and the period register SHALL NOT change while busy=1.

Reset
REQ-033 rst SHALL force: state IDLE, counters 0, dump 0, mode_sel 0, byte_data 0, byte_valid 0, frame_done 0, timeout 0, overflow 0, busy 0.
REQ-034 rst asserted mid-frame SHALL abort the frame with no frame_done pulse and drop any pending byte.

Structure
REQ-035 The FSM state encoding and the SYNC_WORD and HUNT_MAX defaults SHALL reside in a shared package, rx_pkg.
REQ-036 The cycle counter and dump generator SHALL be one sub-module, bit_timer (inputs: period, run; output: dump).

Verification
REQ-037 Scenario, dump timing: start with bit_len=7 -> dump at cycles 8, 16, 24 after start; mode_sel equals the latched mode_cfg.
REQ-038 Scenario, normal frame: bits 1010010111000011, then 00000010, 0x3C, 0x81, with byte_ready=1 -> bytes 0x3C and 0x81 delivered, one frame_done, overflow=0.
REQ-039 Scenario, zero length: sync followed by length 0x00 -> frame_done pulse, no byte_valid, return to IDLE.
REQ-040 Scenario, timeout: 1024 zero bits -> timeout pulse after the 1024th bit, busy=0, no frame_done.
REQ-041 Scenario, overflow: N=2 with byte_ready=0 throughout -> overflow=1 and byte_data=2nd byte; the next start clears overflow.
REQ-042 Scenario, reset mid-frame: rst during PAYLOAD byte 1 -> all outputs at reset values next cycle; no frame_done.
